// File: rtl/gpioemu_job_sequencer_if.sv
// gpioemu_job_sequencer_if: job queue, result queue and peripheral bus bundle.
interface gpioemu_job_sequencer_if;
    logic        job_valid;
    logic        job_ready;
    logic [23:0] job_a1;
    logic [23:0] job_a2;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_w;
    logic [5:0]  res_l;
    logic        res_ovf;
    logic        res_timeout;
    logic [15:0] saddress;
    logic        swr;
    logic        srd;
    logic [31:0] sdata_wr;
    logic [31:0] sdata_rd;
    modport master (
        input  job_valid, job_a1, job_a2, res_ready, sdata_rd,
        output job_ready, res_valid, res_w, res_l, res_ovf, res_timeout,
               saddress, swr, srd, sdata_wr
    );
    modport slave (
        output job_valid, job_a1, job_a2, res_ready, sdata_rd,
        input  job_ready, res_valid, res_w, res_l, res_ovf, res_timeout,
               saddress, swr, srd, sdata_wr
    );
endinterface

// File: rtl/gpioemu_job_sequencer.sv
// gpioemu_job_sequencer: queues multiplier jobs, runs the peripheral bus sequence, queues results.
module gpioemu_job_sequencer #(
    parameter int          IN_DEPTH   = 4,
    parameter int          OUT_DEPTH  = 4,
    parameter int          POLL_LIMIT = 64,
    parameter logic [15:0] ADDR_A1    = 16'h037F,
    parameter logic [15:0] ADDR_A2    = 16'h0388,
    parameter logic [15:0] ADDR_CTRL  = 16'h03A0,
    parameter logic [15:0] ADDR_W     = 16'h0390,
    parameter logic [15:0] ADDR_L     = 16'h0398
) (
    input  logic                           clk,
    input  logic                           reset,
    gpioemu_job_sequencer_if.master        bus,
    output logic                           busy,
    output logic [15:0]                    jobs_done
);
    localparam int IW = $clog2(IN_DEPTH);
    localparam int OW = $clog2(OUT_DEPTH);
    localparam int PW = $clog2(POLL_LIMIT + 1);

    typedef enum logic [2:0] {IDLE, WR_A1, WR_A2, WR_GO, POLL, RD_W, RD_L, PUSH} state_e;

    state_e         state_q, state_d;
    logic [1:0]     ph_q, ph_d;
    logic [PW-1:0]  poll_q, poll_d;
    logic [23:0]    a1_q, a2_q, a1_d, a2_d;
    logic [31:0]    w_q, w_d;
    logic [5:0]     l_q, l_d;
    logic           ovf_q, ovf_d, to_q, to_d;
    logic [15:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           swr_q, swr_d, srd_q, srd_d;
    logic [15:0]    jobs_q;

    logic [47:0]    in_mem_q [IN_DEPTH];
    logic [IW-1:0]  in_wp_q, in_rp_q;
    logic [IW:0]    in_cnt_q;
    logic           in_push, in_pop, in_full, in_empty;

    logic [39:0]    out_mem_q [OUT_DEPTH];
    logic [OW-1:0]  out_wp_q, out_rp_q;
    logic [OW:0]    out_cnt_q;
    logic           out_push, out_pop, out_full;

    logic           bus_st, last;

    assign in_full   = in_cnt_q == (IW+1)'(IN_DEPTH);
    assign in_empty  = in_cnt_q == '0;
    assign in_pop    = state_q == IDLE && !in_empty;
    assign in_push   = bus.job_valid && bus.job_ready;
    // A full input FIFO still accepts when the FSM drains it in the same cycle
    assign bus.job_ready = !reset && (!in_full || in_pop);

    assign out_full  = out_cnt_q == (OW+1)'(OUT_DEPTH);
    assign out_push  = state_q == PUSH && !out_full;
    assign out_pop   = bus.res_valid && bus.res_ready;
    assign bus.res_valid = out_cnt_q != '0;
    assign {bus.res_w, bus.res_l, bus.res_ovf, bus.res_timeout} = out_mem_q[out_rp_q];

    assign {a1_d, a2_d} = in_pop ? in_mem_q[in_rp_q] : {a1_q, a2_q};
    assign bus_st = state_q != IDLE && state_q != PUSH;
    assign last   = ph_q == 2'd2;

    always_ff @(posedge clk) begin
        if (in_push) in_mem_q[in_wp_q] <= {bus.job_a1, bus.job_a2};
        if (out_push) out_mem_q[out_wp_q] <= {w_q, l_q, ovf_q, to_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_wp_q   <= '0;
            in_rp_q   <= '0;
            in_cnt_q  <= '0;
            out_wp_q  <= '0;
            out_rp_q  <= '0;
            out_cnt_q <= '0;
            jobs_q    <= '0;
        end else begin
            in_wp_q   <= in_wp_q + IW'(in_push);
            in_rp_q   <= in_rp_q + IW'(in_pop);
            in_cnt_q  <= in_cnt_q + (IW+1)'(in_push) - (IW+1)'(in_pop);
            out_wp_q  <= out_wp_q + OW'(out_push);
            out_rp_q  <= out_rp_q + OW'(out_pop);
            out_cnt_q <= out_cnt_q + (OW+1)'(out_push) - (OW+1)'(out_pop);
            jobs_q    <= jobs_q + 16'(out_push);
        end
    end

    // Status word: bit1 = done, bit0 = product fits in 32 bits
    always_comb begin
        state_d = state_q;
        poll_d  = poll_q;
        w_d     = w_q;
        l_d     = l_q;
        ovf_d   = ovf_q;
        to_d    = to_q;
        ph_d    = bus_st && !last ? ph_q + 2'd1 : 2'd0;
        unique case (state_q)
            IDLE: if (!in_empty) begin
                state_d = WR_A1;
                poll_d  = '0;
                w_d     = '0;
                l_d     = '0;
                ovf_d   = 1'b0;
                to_d    = 1'b0;
            end
            WR_A1: if (last) state_d = WR_A2;
            WR_A2: if (last) state_d = WR_GO;
            WR_GO: if (last) state_d = POLL;
            POLL: if (last) begin
                poll_d = poll_q + PW'(1);
                if (bus.sdata_rd[1]) begin
                    ovf_d   = ~bus.sdata_rd[0];
                    state_d = RD_W;
                end else if (poll_d == PW'(POLL_LIMIT)) begin
                    to_d    = 1'b1;
                    state_d = PUSH;
                end
            end
            RD_W: if (last) begin
                w_d     = bus.sdata_rd;
                state_d = RD_L;
            end
            RD_L: if (last) begin
                l_d     = bus.sdata_rd[5:0];
                state_d = PUSH;
            end
            PUSH: if (!out_full) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they leave flops glitch-free
    always_comb begin
        addr_d  = state_d == WR_A1 ? ADDR_A1 :
                  state_d == WR_A2 ? ADDR_A2 :
                  (state_d == WR_GO || state_d == POLL) ? ADDR_CTRL :
                  state_d == RD_W ? ADDR_W :
                  state_d == RD_L ? ADDR_L : 16'h0;
        wdata_d = state_d == WR_A1 ? {8'h0, a1_d} :
                  state_d == WR_A2 ? {8'h0, a2_d} : 32'h0;
        swr_d   = (state_d == WR_A1 || state_d == WR_A2 || state_d == WR_GO) && ph_d == 2'd1;
        srd_d   = (state_d == POLL || state_d == RD_W || state_d == RD_L) && ph_d == 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ph_q    <= '0;
            poll_q  <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            w_q     <= '0;
            l_q     <= '0;
            ovf_q   <= 1'b0;
            to_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            swr_q   <= 1'b0;
            srd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            poll_q  <= poll_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            w_q     <= w_d;
            l_q     <= l_d;
            ovf_q   <= ovf_d;
            to_q    <= to_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            swr_q   <= swr_d;
            srd_q   <= srd_d;
        end
    end

    assign bus.saddress = addr_q;
    assign bus.sdata_wr = wdata_q;
    assign bus.swr      = swr_q;
    assign bus.srd      = srd_q;
    assign busy         = state_q != IDLE;
    assign jobs_done    = jobs_q;
endmodule
